// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte framing of the load stream.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6,
        CHK    = 3'd7
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = stream source / memory side, slave = the loader itself.
interface imem_loader_if;

    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// Assembles big-endian 32-bit words from a byte stream; the first byte of a
// word lands in [31:24] and word_ready flags the cycle the 4th byte is taken.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (take) begin
            shift_d = {shift_q[15:0], byte_in};
            idx_d   = idx_q + 2'd1;
        end
    end

    // The word is presented combinationally so the loader can latch it on
    // the same edge that accepts the final byte.
    assign word       = {shift_q, byte_in};
    assign word_ready = take && !clear && (idx_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory and holds the
// core in reset until it is loaded. Optional trailer checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          WORDS     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 8 * HDR_BYTES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    logic               take;
    logic [CNT_W-1:0]   cnt_full;
    logic [31:0]        pack_word;
    logic               pack_ready;
    logic               pack_take;
    logic               pack_clear;

    assign take      = bus.in_valid && in_ready_q;
    assign cnt_full  = {cnt_q[CNT_W-9:0], bus.in_byte};
    assign pack_take = take && (state_q == DATA);
    assign pack_clear = (state_q != DATA);

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .take       (pack_take),
        .byte_in    (bus.in_byte),
        .word       (pack_word),
        .word_ready (pack_ready)
    );

    // Next state plus all outputs decoded from the next state, so every
    // output is a flop that already reflects the state it belongs to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR_HI;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            HDR_HI: begin
                if (take) begin
                    cnt_d   = cnt_full;
                    state_d = HDR_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ bus.in_byte;
`endif
                end
            end
            HDR_LO: begin
                if (take) begin
                    cnt_d = cnt_full;
                    idx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ bus.in_byte;
`endif
                    if (cnt_full == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else if (32'(cnt_full) > 32'(WORDS)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ bus.in_byte;
`endif
                    if (pack_ready) begin
                        state_d = WRITE;
                        addr_d  = BASE_ADDR + (32'(idx_q) << 2);
                        wdata_d = pack_word;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_q + CNT_W'(1);
                if (idx_q + CNT_W'(1) == cnt_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (take) begin
                    state_d = (bus.in_byte == chk_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                     (state_d == DATA)   || (state_d == CHK);
        we_d       = (state_d == WRITE);
        busy_d     = (state_d == HDR_HI) || (state_d == HDR_LO) ||
                     (state_d == DATA)   || (state_d == WRITE)  ||
                     (state_d == CHK);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_rst_d  = (state_d != DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_rst        = cpu_rst_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: a stream-level model predicts writes,
// their timing and the load status, and is checked every cycle.
module tb_imem_loader;

    localparam int          WORDS = 256;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst, busy, done, err;

    imem_loader_if bus();

    imem_loader #(
        .WORDS     (WORDS),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0]  stream[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Stream-level model: a load is idle/loading/done/error; header bytes
    // give the word count, every 4 data bytes owe one write the next cycle.
    typedef enum {S_IDLE, S_LOAD, S_DONE, S_ERR} mstat_e;
    mstat_e      m_stat = S_IDLE;
    bit          m_valid = 1'b0;
    bit          m_we = 1'b0;
    bit          m_trailer = 1'b0;
    logic [31:0] m_addr, m_data, m_word;
    logic [7:0]  m_xor, m_b;
    int          m_hdr_n, m_data_n, m_widx, m_cnt;

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("imem_we",  32'(bus.imem_we), 32'(m_we));
            checkOutput("in_ready", 32'(bus.in_ready), 32'(m_stat == S_LOAD && !m_we));
            checkOutput("busy",     32'(busy),    32'(m_stat == S_LOAD));
            checkOutput("done",     32'(done),    32'(m_stat == S_DONE));
            checkOutput("err",      32'(err),     32'(m_stat == S_ERR));
            checkOutput("cpu_rst",  32'(cpu_rst), 32'(m_stat != S_DONE));
            if (m_we) begin
                checkOutput("imem_addr",  bus.imem_addr,  m_addr);
                checkOutput("imem_wdata", bus.imem_wdata, m_data);
            end
        end
        if (bus.imem_we === 1'b1) begin
            log_addr.push_back(bus.imem_addr);
            log_data.push_back(bus.imem_wdata);
        end

        if (rst) begin
            m_valid = 1'b1;
            m_stat  = S_IDLE;
            m_we    = 1'b0;
        end else if (m_valid) begin
            if (m_we) begin
                m_we = 1'b0;
                m_widx++;
                if (m_widx == m_cnt) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    m_trailer = 1'b1;
`else
                    m_stat = S_DONE;
`endif
                end
            end else if (m_stat == S_LOAD && bus.in_valid) begin
                m_b = bus.in_byte;
                if (m_hdr_n < 2) begin
                    m_cnt = (m_cnt << 8) | int'(m_b);
                    m_hdr_n++;
                    m_xor ^= m_b;
                    if (m_hdr_n == 2) begin
                        if (m_cnt == 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            m_trailer = 1'b1;
`else
                            m_stat = S_DONE;
`endif
                        end else if (m_cnt > WORDS) begin
                            m_stat = S_ERR;
                        end
                    end
                end else if (m_trailer) begin
                    m_stat    = (m_b == m_xor) ? S_DONE : S_ERR;
                    m_trailer = 1'b0;
                end else begin
                    m_word = {m_word[23:0], m_b};
                    m_data_n++;
                    m_xor ^= m_b;
                    if (m_data_n % 4 == 0) begin
                        m_we   = 1'b1;
                        m_addr = BASE + 32'(4 * m_widx);
                        m_data = m_word;
                    end
                end
            end else if (m_stat != S_LOAD && start) begin
                m_stat    = S_LOAD;
                m_hdr_n   = 0;
                m_data_n  = 0;
                m_widx    = 0;
                m_cnt     = 0;
                m_xor     = 8'h00;
                m_trailer = 1'b0;
            end
        end
    end

    task automatic addTrailer(input bit bad);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        stream.push_back(bad ? (x ^ 8'h01) : x);
`else
        if (bad) stream.push_back(8'h00);
`endif
    endtask

    task automatic buildStream(input int nwords, input bit bad);
        stream.delete();
        stream.push_back(8'(nwords >> 8));
        stream.push_back(8'(nwords));
        for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom));
        addTrailer(bad);
    endtask

    task automatic loadBasic();
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
        addTrailer(1'b0);
    endtask

    task automatic clearLog();
        log_addr.delete();
        log_data.delete();
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic applyStimulus(input int n_send, input int gap_pct, input bit do_start, input bit poke_start);
        int  guard;
        bit  acc;
        bit  v;
        if (do_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < n_send; i++) begin
            guard = 0;
            acc   = 1'b0;
            while (!acc) begin
                v = ($urandom_range(99) >= gap_pct);
                bus.in_valid = v;
                bus.in_byte  = v ? stream[i] : 8'($urandom);
                start = poke_start && (i > 0) && (i < n_send - 1) && ($urandom_range(15) == 0);
                @(negedge clk);
                acc = v && bus.in_ready;
                @(posedge clk); #1;
                guard++;
                if (!acc && guard > 200) begin
                    checkOutput("byte_accept_timeout", 32'(i), 32'hFFFF_FFFF);
                    bus.in_valid = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic waitEnd();
        int g;
        g = 0;
        while (!(done === 1'b1 || err === 1'b1) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) checkOutput("end_timeout", 32'(done | err), 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic checkBasicLog(input string tag);
        checkOutput({tag, "_nwrites"}, 32'(log_addr.size()), 32'd2);
        if (log_addr.size() >= 2) begin
            checkOutput({tag, "_addr0"}, log_addr[0], 32'h0000_0000);
            checkOutput({tag, "_data0"}, log_data[0], 32'h2008_0005);
            checkOutput({tag, "_addr1"}, log_addr[1], 32'h0000_0004);
            checkOutput({tag, "_data1"}, log_data[1], 32'hAC08_0000);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("rst_imem_we",  32'(bus.imem_we),  32'h0);
        checkOutput("rst_imem_addr", bus.imem_addr, BASE);
        checkOutput("rst_imem_wdata", bus.imem_wdata, 32'h0);
        checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_err",  32'(err),  32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic load");
        loadBasic(); clearLog();
        applyStimulus(stream.size(), 0, 1'b1, 1'b0);
        waitEnd();
        checkBasicLog("basic");
        checkOutput("basic_done", 32'(done), 32'h1);
        checkOutput("basic_cpu_rst", 32'(cpu_rst), 32'h0);

        $display("[TB] backpressure and gaps");
        loadBasic(); clearLog();
        applyStimulus(stream.size(), 50, 1'b1, 1'b1);
        waitEnd();
        checkBasicLog("gaps");
        checkOutput("gaps_done", 32'(done), 32'h1);

        $display("[TB] empty program");
        stream = '{8'h00, 8'h00}; addTrailer(1'b0); clearLog();
        applyStimulus(stream.size(), 30, 1'b1, 1'b0);
        waitEnd();
        checkOutput("empty_nwrites", 32'(log_addr.size()), 32'd0);
        checkOutput("empty_done", 32'(done), 32'h1);

        $display("[TB] overflow");
        stream = '{8'h01, 8'h01}; clearLog();
        applyStimulus(stream.size(), 20, 1'b1, 1'b0);
        waitEnd();
        checkOutput("ovf_err", 32'(err), 32'h1);
        checkOutput("ovf_in_ready", 32'(bus.in_ready), 32'h0);
        checkOutput("ovf_cpu_rst", 32'(cpu_rst), 32'h1);
        checkOutput("ovf_nwrites", 32'(log_addr.size()), 32'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("ovf_restart_busy", 32'(busy), 32'h1);
        checkOutput("ovf_restart_ready", 32'(bus.in_ready), 32'h1);
        stream = '{8'h00, 8'h00}; addTrailer(1'b0);
        applyStimulus(stream.size(), 0, 1'b0, 1'b0);
        waitEnd();
        checkOutput("ovf_recover_done", 32'(done), 32'h1);

        $display("[TB] reset mid-load");
        buildStream(3, 1'b0);
        applyStimulus(8, 20, 1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midrst_imem_we", 32'(bus.imem_we), 32'h0);
        checkOutput("midrst_cpu_rst", 32'(cpu_rst), 32'h1);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'h0);
        loadBasic(); clearLog();
        applyStimulus(stream.size(), 25, 1'b1, 1'b0);
        waitEnd();
        checkBasicLog("midrst_reload");

        $display("[TB] random loads");
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 12);
            buildStream(n, 1'b0); clearLog();
            applyStimulus(stream.size(), $urandom_range(0, 60), 1'b1, 1'b1);
            waitEnd();
            checkOutput("rand_nwrites", 32'(log_addr.size()), 32'(n));
            checkOutput("rand_done", 32'(done), 32'h1);
        end

        $display("[TB] full-depth load");
        buildStream(WORDS, 1'b0); clearLog();
        applyStimulus(stream.size(), 0, 1'b1, 1'b0);
        waitEnd();
        checkOutput("full_nwrites", 32'(log_addr.size()), 32'(WORDS));
        if (log_addr.size() == WORDS)
            checkOutput("full_last_addr", log_addr[WORDS-1], 32'h0000_03FC);
        checkOutput("full_done", 32'(done), 32'h1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] bad checksum");
        loadBasic();
        stream[stream.size()-1] = stream[stream.size()-1] ^ 8'h01;
        clearLog();
        applyStimulus(stream.size(), 10, 1'b1, 1'b0);
        waitEnd();
        checkOutput("chk_bad_err", 32'(err), 32'h1);
        checkOutput("chk_bad_cpu_rst", 32'(cpu_rst), 32'h1);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
